mux_scan_driver: RTL and testbench

Upstream driver for the team's 4:1 multiplexer. It accepts a 4-bit word through a valid/ready handshake and registers the word onto the mux data inputs `in0`..`in3`. It then steps the mux select (`addr1`,`addr0`) through 00, 01, 10, 11, holding each address for a programmable number of cycles. It samples the mux's combinational `out` (returned as `mux_out`) and emits one serial bit per address, plus a completion pulse.

---
 rtl/mux_scan_driver.sv | 109 ++++++++++
 tb/tb_mux_scan_driver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_driver.sv
// Drives a 4:1 mux: latches a 4-bit word onto in0..in3, walks the select through
// 00..11 holding each address BIT_CYCLES cycles, and serialises the sampled mux output.
module mux_scan_driver #(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [3:0] load_data,
    output logic       load_ready,
    output logic       addr0,
    output logic       addr1,
    output logic       in0,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       mux_out,
    output logic       serial_out,
    output logic       serial_valid,
    output logic       done,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(BIT_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] word_q, word_d;
    logic       serial_out_q, serial_out_d;
    logic       serial_valid_q, serial_valid_d;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        hold_d         = hold_q;
        word_d         = word_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = 2'd0;
                if (load_valid) begin
                    word_d  = load_data;
                    hold_d  = 8'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    // Last cycle of this address: capture the mux result and advance.
                    serial_out_d   = mux_out;
                    serial_valid_d = 1'b1;
                    hold_d         = 8'd0;
                    if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= 2'd0;
            hold_q         <= 8'd0;
            word_q         <= 4'd0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            hold_q         <= hold_d;
            word_q         <= word_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
        end
    end

    assign addr1        = idx_q[1];
    assign addr0        = idx_q[0];
    assign in0          = word_q[0];
    assign in1          = word_q[1];
    assign in2          = word_q[2];
    assign in3          = word_q[3];
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign load_ready   = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_mux_scan_driver.sv
// Bench for mux_scan_driver: one instance with BIT_CYCLES=1 and one with BIT_CYCLES=3,
// each looped back through a behavioural 4:1 mux.
module tb_mux_scan_driver;

    logic clk;
    logic reset;

    logic       load_valid_b1, load_ready_b1, addr0_b1, addr1_b1;
    logic       in0_b1, in1_b1, in2_b1, in3_b1;
    logic       mux_out_b1, serial_out_b1, serial_valid_b1, done_b1, busy_b1;
    logic [3:0] load_data_b1;
    logic       force_b1;

    logic       load_valid_b3, load_ready_b3, addr0_b3, addr1_b3;
    logic       in0_b3, in1_b3, in2_b3, in3_b3;
    logic       mux_out_b3, serial_out_b3, serial_valid_b3, done_b3, busy_b3;
    logic [3:0] load_data_b3;

    logic [1:0] sel_b1, sel_b3;
    logic [3:0] word_b1, word_b3;

    int nvec = 0;
    int nbad = 0;

    assign sel_b1     = {addr1_b1, addr0_b1};
    assign word_b1    = {in3_b1, in2_b1, in1_b1, in0_b1};
    assign mux_out_b1 = force_b1 ? 1'b1 : word_b1[sel_b1];
    assign sel_b3     = {addr1_b3, addr0_b3};
    assign word_b3    = {in3_b3, in2_b3, in1_b3, in0_b3};
    assign mux_out_b3 = word_b3[sel_b3];

    mux_scan_driver #(.BIT_CYCLES(1)) u_b1 (
        .clk(clk), .reset(reset),
        .load_valid(load_valid_b1), .load_data(load_data_b1), .load_ready(load_ready_b1),
        .addr0(addr0_b1), .addr1(addr1_b1),
        .in0(in0_b1), .in1(in1_b1), .in2(in2_b1), .in3(in3_b1),
        .mux_out(mux_out_b1), .serial_out(serial_out_b1), .serial_valid(serial_valid_b1),
        .done(done_b1), .busy(busy_b1)
    );

    mux_scan_driver #(.BIT_CYCLES(3)) u_b3 (
        .clk(clk), .reset(reset),
        .load_valid(load_valid_b3), .load_data(load_data_b3), .load_ready(load_ready_b3),
        .addr0(addr0_b3), .addr1(addr1_b3),
        .in0(in0_b3), .in1(in1_b3), .in2(in2_b3), .in3(in3_b3),
        .mux_out(mux_out_b3), .serial_out(serial_out_b3), .serial_valid(serial_valid_b3),
        .done(done_b3), .busy(busy_b3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] data;
        logic       force_one;
        logic [3:0] bits;   // bit k = expected serial bit for address k
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full B=1 scan starting from IDLE; checks every cycle E0..E5.
    task automatic run_scan1(input logic [3:0] data, input logic [3:0] bits);
        load_valid_b1 = 1'b1;
        load_data_b1  = data;
        step();
        load_valid_b1 = 1'b0;
        chk("accept_word", word_b1, data);
        chk("accept_busy", {3'b0, busy_b1}, 4'd1);
        chk("accept_ready", {3'b0, load_ready_b1}, 4'd0);
        chk("accept_sv", {3'b0, serial_valid_b1}, 4'd0);
        for (int k = 0; k < 4; k++) begin
            chk("scan_sel", {2'b0, sel_b1}, 4'(k));
            step();
            chk("scan_sv", {3'b0, serial_valid_b1}, 4'd1);
            chk("scan_bit", {3'b0, serial_out_b1}, {3'b0, bits[k]});
            chk("scan_done", {3'b0, done_b1}, (k == 3) ? 4'd1 : 4'd0);
            chk("scan_word", word_b1, data);
        end
        chk("done_sel", {2'b0, sel_b1}, 4'd3);
        chk("done_ready", {3'b0, load_ready_b1}, 4'd0);
        step();
        $display("scan data=%b bits=%b finished", data, bits);
        chk("idle_ready", {3'b0, load_ready_b1}, 4'd1);
        chk("idle_done", {3'b0, done_b1}, 4'd0);
        chk("idle_sv", {3'b0, serial_valid_b1}, 4'd0);
        chk("idle_busy", {3'b0, busy_b1}, 4'd0);
        chk("idle_sel", {2'b0, sel_b1}, 4'd0);
    endtask

    initial begin
        vecs[0] = '{data: 4'b0001, force_one: 1'b0, bits: 4'b0001};
        vecs[1] = '{data: 4'b1110, force_one: 1'b0, bits: 4'b1110};
        vecs[2] = '{data: 4'b0000, force_one: 1'b1, bits: 4'b1111};
        vecs[3] = '{data: 4'b1010, force_one: 1'b0, bits: 4'b1010};

        reset         = 1'b1;
        load_valid_b1 = 1'b0;
        load_data_b1  = 4'd0;
        force_b1      = 1'b0;
        load_valid_b3 = 1'b0;
        load_data_b3  = 4'd0;
        #12;
        chk("rst_ready", {3'b0, load_ready_b1}, 4'd1);
        chk("rst_busy", {3'b0, busy_b1}, 4'd0);
        chk("rst_word", word_b1, 4'd0);
        chk("rst_sel", {2'b0, sel_b1}, 4'd0);
        chk("rst_sv_so_done", {1'b0, serial_valid_b1, serial_out_b1, done_b1}, 4'd0);
        chk("rst_ready_b3", {3'b0, load_ready_b3}, 4'd1);
        reset = 1'b0;
        step();

        // Table-driven B=1 scans
        for (int v = 0; v < 4; v++) begin
            force_b1 = vecs[v].force_one;
            run_scan1(vecs[v].data, vecs[v].bits);
            force_b1 = 1'b0;
        end

        // load_valid held high; data changes mid-scan and must be ignored
        load_valid_b1 = 1'b1;
        load_data_b1  = 4'b1001;
        step();
        chk("hold_accept", word_b1, 4'b1001);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) load_data_b1 = 4'b0110;
            step();
            chk("hold_sv", {3'b0, serial_valid_b1}, 4'd1);
            chk("hold_bit", {3'b0, serial_out_b1}, (k == 0 || k == 3) ? 4'd1 : 4'd0);
            chk("hold_word", word_b1, 4'b1001);
        end
        step();
        chk("hold_e5_ready", {3'b0, load_ready_b1}, 4'd1);
        chk("hold_e5_word", word_b1, 4'b1001);
        run_scan1(4'b0110, 4'b0110);

        // Asynchronous reset between E2 and E3 of a scan
        load_valid_b1 = 1'b1;
        load_data_b1  = 4'b1010;
        step();
        load_valid_b1 = 1'b0;
        step();
        step();
        chk("pre_rst_sv", {3'b0, serial_valid_b1}, 4'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_sel", {2'b0, sel_b1}, 4'd0);
        chk("arst_word", word_b1, 4'd0);
        chk("arst_sv", {3'b0, serial_valid_b1}, 4'd0);
        chk("arst_busy", {3'b0, busy_b1}, 4'd0);
        chk("arst_ready", {3'b0, load_ready_b1}, 4'd1);
        step();
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_done", {3'b0, done_b1}, 4'd0);
            chk("post_rst_busy", {3'b0, busy_b1}, 4'd0);
        end
        run_scan1(4'b1010, 4'b1010);

        // B=3 scan of 4'b0110
        load_valid_b3 = 1'b1;
        load_data_b3  = 4'b0110;
        step();
        load_valid_b3 = 1'b0;
        chk("b3_accept", word_b3, 4'b0110);
        for (int n = 1; n <= 13; n++) begin
            logic [3:0] ebits;
            int         esel;
            ebits = 4'b0110;
            esel  = (n >= 13) ? 0 : ((n / 3 > 3) ? 3 : n / 3);
            step();
            chk("b3_sv", {3'b0, serial_valid_b3}, (n % 3 == 0 && n <= 12) ? 4'd1 : 4'd0);
            if (n % 3 == 0 && n <= 12)
                chk("b3_bit", {3'b0, serial_out_b3}, {3'b0, ebits[n / 3 - 1]});
            chk("b3_done", {3'b0, done_b3}, (n == 12) ? 4'd1 : 4'd0);
            chk("b3_sel", {2'b0, sel_b3}, 4'(esel));
            chk("b3_ready", {3'b0, load_ready_b3}, (n == 13) ? 4'd1 : 4'd0);
        end
        $display("scan B=3 data=0110 finished");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
